// File: rtl/midi_pkg.sv
// Shared MIDI constants, message layout and helpers for the MIDI message receiver.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF    = 4'h8;
    localparam logic [3:0] NOTE_ON     = 4'h9;
    localparam logic [3:0] POLY_AT     = 4'hA;
    localparam logic [3:0] CTRL_CHANGE = 4'hB;
    localparam logic [3:0] PROG_CHANGE = 4'hC;
    localparam logic [3:0] CHAN_AT     = 4'hD;
    localparam logic [3:0] PITCH_BEND  = 4'hE;

    localparam int unsigned MSG_STATUS_LSB = 20;
    localparam int unsigned MSG_CHAN_LSB   = 16;
    localparam int unsigned MSG_DATA1_LSB  = 8;
    localparam int unsigned MSG_DATA2_LSB  = 0;

    typedef logic [23:0] midi_msg_t;

    function automatic int unsigned bit_ticks(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic logic two_data_bytes(input logic [3:0] status);
        logic two;
        case (status)
            NOTE_OFF, NOTE_ON, POLY_AT, CTRL_CHANGE, PITCH_BEND: two = 1'b1;
            PROG_CHANGE, CHAN_AT:                                two = 1'b0;
            default:                                             two = 1'b1;
        endcase
        return two;
    endfunction

    // Zero-velocity note-on is reported as note-off when requested.
    function automatic midi_msg_t make_msg(input logic [7:0] status_byte, input logic [7:0] d1,
                                           input logic [7:0] d2, input logic vel0_as_off);
        midi_msg_t m;
        m = '0;
        if (vel0_as_off && (status_byte[7:4] == NOTE_ON) && (d2 == 8'h00)) begin
            m[MSG_STATUS_LSB +: 4] = NOTE_OFF;
        end else begin
            m[MSG_STATUS_LSB +: 4] = status_byte[7:4];
        end
        m[MSG_CHAN_LSB  +: 4] = status_byte[3:0];
        m[MSG_DATA1_LSB +: 8] = d1;
        m[MSG_DATA2_LSB +: 8] = d2;
        return m;
    endfunction

endpackage

// File: rtl/midi_message_rx_if.sv
// Message-queue side of the MIDI receiver: FWFT head, occupancy and emit notification.
interface midi_message_rx_if #(
    parameter int unsigned CNT_W = 3
);
    logic             msg_pop;
    logic [23:0]      msg_data;
    logic             msg_empty;
    logic [CNT_W-1:0] msg_count;
    logic [31:0]      msg_latest;
    logic             msg_valid;

    modport master (
        input  msg_pop,
        output msg_data, msg_empty, msg_count, msg_latest, msg_valid
    );

    modport slave (
        output msg_pop,
        input  msg_data, msg_empty, msg_count, msg_latest, msg_valid
    );
endinterface

// File: rtl/midi_uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchronizer, mid-bit sampling, framing check on the stop bit.
module midi_uart_byte_rx #(
    parameter int unsigned BIT_TICKS = 3200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_TICKS / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    // Metastability synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            sync2_r <= sync1_r;
        end
    end

    // Byte framing FSM with single-cycle byte_valid / framing_err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            rx_byte     <= 8'h00;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (!sync2_r) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_CNT) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        // A start bit that has gone high again by mid-bit is just noise.
                        state_r   <= sync2_r ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_r   <= '0;
                        shift_r <= {sync2_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        if (sync2_r) begin
                            rx_byte    <= shift_r;
                            byte_valid <= 1'b1;
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: rtl/midi_message_rx.sv
// MIDI channel-voice message assembler with running status, feeding a small FWFT message queue.
module midi_message_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BAUD        = 31250,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter bit          VEL0_AS_OFF = 1'b1
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              midi_in,
    midi_message_rx_if.master msg,
    output logic              rx_busy,
    output logic              framing_err,
    output logic              overrun
);

    localparam int unsigned BIT_TICKS = bit_ticks(CLK_HZ, BAUD);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0] rx_byte_s;
    logic       byte_valid_s;
    logic       byte_ferr_s;

    midi_uart_byte_rx #(
        .BIT_TICKS (BIT_TICKS)
    ) u_byte_rx (
        .clk         (CLK100MHZ),
        .reset       (reset),
        .rx_in       (midi_in),
        .rx_byte     (rx_byte_s),
        .byte_valid  (byte_valid_s),
        .framing_err (byte_ferr_s),
        .busy        (rx_busy)
    );

    assign framing_err = byte_ferr_s;

    logic [7:0] status_r, status_nxt_s;
    logic       rs_valid_r, rs_valid_nxt_s;
    logic       idx_r, idx_nxt_s;
    logic [7:0] data1_r, data1_nxt_s;
    logic       emit_s;
    midi_msg_t  emit_msg_s;

    // Byte classification and message assembly.
    always_comb begin
        status_nxt_s   = status_r;
        rs_valid_nxt_s = rs_valid_r;
        idx_nxt_s      = idx_r;
        data1_nxt_s    = data1_r;
        emit_s         = 1'b0;
        emit_msg_s     = '0;
        if (byte_ferr_s) begin
            idx_nxt_s = 1'b0;
        end else if (!byte_valid_s) begin
            idx_nxt_s = idx_r;
        end else if (rx_byte_s >= 8'hF8) begin
            // Real-time bytes may interleave anywhere without disturbing a message.
            idx_nxt_s = idx_r;
        end else if (rx_byte_s >= 8'hF0) begin
            rs_valid_nxt_s = 1'b0;
            idx_nxt_s      = 1'b0;
        end else if (rx_byte_s[7]) begin
            status_nxt_s   = rx_byte_s;
            rs_valid_nxt_s = 1'b1;
            idx_nxt_s      = 1'b0;
        end else if (!rs_valid_r) begin
            idx_nxt_s = idx_r;
        end else if (!idx_r && two_data_bytes(status_r[7:4])) begin
            data1_nxt_s = rx_byte_s;
            idx_nxt_s   = 1'b1;
        end else if (!idx_r) begin
            emit_s     = 1'b1;
            emit_msg_s = make_msg(status_r, rx_byte_s, 8'h00, VEL0_AS_OFF);
            idx_nxt_s  = 1'b0;
        end else begin
            emit_s     = 1'b1;
            emit_msg_s = make_msg(status_r, data1_r, rx_byte_s, VEL0_AS_OFF);
            idx_nxt_s  = 1'b0;
        end
    end

    // Parser registers; status survives completed messages for running status.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            status_r   <= 8'h00;
            rs_valid_r <= 1'b0;
            idx_r      <= 1'b0;
            data1_r    <= 8'h00;
        end else begin
            status_r   <= status_nxt_s;
            rs_valid_r <= rs_valid_nxt_s;
            idx_r      <= idx_nxt_s;
            data1_r    <= data1_nxt_s;
        end
    end

    midi_msg_t        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic             drop_s;

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign pop_ok_s  = msg.msg_pop && (count_r != '0);
    assign push_ok_s = emit_s && ((count_r != FULL_CNT) || pop_ok_s);
    assign drop_s    = emit_s && (count_r == FULL_CNT) && !pop_ok_s;

    // Message queue storage, pointers and occupancy.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            fifo_mem_r <= '{default: '0};
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= emit_msg_s;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    logic      msg_valid_r;
    midi_msg_t latest_r;
    logic      overrun_r;

    // Emit notification, last-message holding register and sticky overrun.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            msg_valid_r <= 1'b0;
            latest_r    <= '0;
            overrun_r   <= 1'b0;
        end else begin
            msg_valid_r <= emit_s;
            if (emit_s) begin
                latest_r <= emit_msg_s;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign msg.msg_data   = fifo_mem_r[rd_ptr_r];
    assign msg.msg_empty  = (count_r == '0);
    assign msg.msg_count  = count_r;
    assign msg.msg_latest = {8'h00, latest_r};
    assign msg.msg_valid  = msg_valid_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_midi_message_rx.sv
// Scoreboard bench: serial frames in, a byte-level MIDI model predicts emitted and queued messages.
module tb_midi_message_rx;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int BT   = 16;
    localparam int HALF = BT / 2;
    // Edge index (from the frame's first edge) of the stop-bit sample:
    // two synchronizer flops, one cycle to leave IDLE, half a bit, then nine full bits.
    localparam int STOP_SAMPLE = 3 + HALF + 9 * BT;
    localparam int LATENCY     = STOP_SAMPLE + 2;

    logic clk = 1'b0;
    logic reset;
    logic midi_in;
    logic busy, ferr, ovr;
    logic r_busy, r_ferr, r_ovr;

    midi_message_rx_if mif ();
    midi_message_rx_if rif ();

    assign rif.msg_pop = !rif.msg_empty;

    midi_message_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4), .VEL0_AS_OFF(1'b1)) dut (
        .CLK100MHZ (clk), .reset (reset), .midi_in (midi_in), .msg (mif),
        .rx_busy (busy), .framing_err (ferr), .overrun (ovr)
    );

    midi_message_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4), .VEL0_AS_OFF(1'b0)) dut_raw (
        .CLK100MHZ (clk), .reset (reset), .midi_in (midi_in), .msg (rif),
        .rx_busy (r_busy), .framing_err (r_ferr), .overrun (r_ovr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int frame_start = 0;
    int last_valid_cyc = -1;
    int ferr_seen = 0;
    int exp_ferr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [23:0] exp_valid_q [$];
    logic [23:0] exp_raw_q [$];
    logic [23:0] fifo_q [$];
    logic        exp_overrun = 1'b0;
    logic [7:0]  m_status = 8'h00;
    logic        m_rs = 1'b0;
    logic [7:0]  m_pend [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        int need;
        logic [7:0] d1, d2;
        logic [23:0] raw, off;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_rs = 1'b0; m_pend.delete(); return; end
        if (b[7]) begin m_status = b; m_rs = 1'b1; m_pend.delete(); return; end
        if (!m_rs) return;
        m_pend.push_back(b);
        need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
        if (m_pend.size() == need) begin
            d1  = m_pend[0];
            d2  = (need == 2) ? m_pend[1] : 8'h00;
            raw = {m_status, d1, d2};
            off = (m_status[7:4] == 4'h9 && d2 == 8'h00) ? {4'h8, m_status[3:0], d1, d2} : raw;
            exp_valid_q.push_back(off);
            exp_raw_q.push_back(raw);
            if (fifo_q.size() < 4) fifo_q.push_back(off);
            else exp_overrun = 1'b1;
            m_pend.delete();
        end
    endfunction

    function automatic void model_reset();
        m_rs = 1'b0;
        m_pend.delete();
        fifo_q.delete();
        exp_overrun = 1'b0;
    endfunction

    // One 8N1 frame at the bench baud rate; pop_at >= 0 pulses msg_pop at that edge of the frame.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int pop_at);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(negedge clk);
        frame_start = cyc;
        if (stop) model_byte(b);
        else begin m_pend.delete(); exp_ferr++; end
        for (int k = 0; k < 10 * BT; k++) begin
            midi_in     = frame[k / BT];
            mif.msg_pop = (k == pop_at);
            @(negedge clk);
        end
        midi_in     = 1'b1;
        mif.msg_pop = 1'b0;
        repeat (BT) @(negedge clk);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1, -1);
        send_byte(b, 1'b1, -1);
        send_byte(c, 1'b1, -1);
    endtask

    task automatic pop_one();
        logic [23:0] tmp;
        @(negedge clk);
        if (fifo_q.size() == 0) begin
            mif.msg_pop = 1'b1;
            @(negedge clk);
            mif.msg_pop = 1'b0;
            check("pop_empty_count", 32'(mif.msg_count), 32'd0);
        end else begin
            check("pop_head", 32'(mif.msg_data), 32'(fifo_q[0]));
            mif.msg_pop = 1'b1;
            @(negedge clk);
            mif.msg_pop = 1'b0;
            tmp = fifo_q.pop_front();
        end
    endtask

    task automatic drain();
        while (fifo_q.size() > 0) pop_one();
    endtask

    task automatic check_fifo(input string tag);
        @(negedge clk);
        check({tag, "_count"}, 32'(mif.msg_count), 32'(fifo_q.size()));
        check({tag, "_empty"}, 32'(mif.msg_empty), 32'(fifo_q.size() == 0));
        if (fifo_q.size() != 0) check({tag, "_head"}, 32'(mif.msg_data), 32'(fifo_q[0]));
        check({tag, "_overrun"}, 32'(ovr), 32'(exp_overrun));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"},    32'(mif.msg_data), 32'd0);
        check({tag, "_empty"},   32'(mif.msg_empty), 32'd1);
        check({tag, "_count"},   32'(mif.msg_count), 32'd0);
        check({tag, "_latest"},  mif.msg_latest, 32'd0);
        check({tag, "_valid"},   32'(mif.msg_valid), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_ferr"},    32'(ferr), 32'd0);
        check({tag, "_overrun"}, 32'(ovr), 32'd0);
    endtask

    // Monitor: every emit and every raw-instance queue entry is matched against the model.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (ferr === 1'b1) ferr_seen++;
            if (mif.msg_valid === 1'b1) begin
                last_valid_cyc = cyc;
                if (exp_valid_q.size() == 0) check("unexpected_msg_valid", 32'(mif.msg_valid), 32'd0);
                else begin
                    e = exp_valid_q.pop_front();
                    check("msg_latest", mif.msg_latest, {8'h00, e});
                end
            end
            if (rif.msg_empty === 1'b0) begin
                if (exp_raw_q.size() == 0) check("unexpected_raw_msg", 32'(rif.msg_data), 32'hFFFF_FFFF);
                else begin
                    e = exp_raw_q.pop_front();
                    check("raw_msg_data", 32'(rif.msg_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [23:0] tmp;
        int r;
        reset = 1'b1; midi_in = 1'b1; mif.msg_pop = 1'b0;
        repeat (4) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic note-on with emit latency
        send3(8'h90, 8'h3C, 8'h64);
        check("latency", 32'(last_valid_cyc - frame_start), 32'(LATENCY));
        check("t1_latest", mif.msg_latest, 32'h0090_3C64);
        check_fifo("t1");
        drain();

        // Running status and a one-data-byte message
        send3(8'h90, 8'h3C, 8'h64); pop_one();
        send_byte(8'h40, 1'b1, -1); send_byte(8'h7F, 1'b1, -1); pop_one();
        send_byte(8'hC5, 1'b1, -1); send_byte(8'h07, 1'b1, -1);
        check_fifo("t2");
        drain();

        // Zero velocity note-on
        send3(8'h90, 8'h3C, 8'h00);
        check_fifo("t3");
        drain();

        // Real-time interleave, then system common clears running status
        send_byte(8'h90, 1'b1, -1); send_byte(8'hF8, 1'b1, -1); send_byte(8'h3C, 1'b1, -1);
        send_byte(8'hFE, 1'b1, -1); send_byte(8'h64, 1'b1, -1);
        send3(8'hF0, 8'h3C, 8'h64);
        check_fifo("t4");
        drain();

        // Framing error mid-message keeps status, restarts data
        send_byte(8'h90, 1'b1, -1); send_byte(8'h3C, 1'b1, -1);
        send_byte(8'h55, 1'b0, -1);
        send_byte(8'h64, 1'b1, -1); send_byte(8'h7F, 1'b1, -1);
        check("t5_ferr_count", 32'(ferr_seen), 32'(exp_ferr));
        check_fifo("t5a");
        drain();
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0; model_reset();
        send_byte(8'h40, 1'b1, -1); send_byte(8'h7F, 1'b1, -1);
        check_fifo("t5_nostatus");
        // Short low glitch
        @(negedge clk); midi_in = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd1);
        @(negedge clk); midi_in = 1'b1;
        repeat (2 * BT) @(negedge clk);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_ferr", 32'(ferr_seen), 32'(exp_ferr));

        // Fill past depth, overrun, pop, simultaneous push+pop when full
        for (int i = 0; i < 5; i++) send3(8'hE0, 8'(i), 8'h40);
        check_fifo("t6_full");
        pop_one();
        check_fifo("t6_pop");
        send3(8'hE0, 8'h05, 8'h40);
        check_fifo("t6_refill");
        send_byte(8'hE0, 1'b1, -1); send_byte(8'h06, 1'b1, -1);
        @(negedge clk);
        check("t6_pp_head", 32'(mif.msg_data), 32'(fifo_q[0]));
        tmp = fifo_q.pop_front();
        send_byte(8'h40, 1'b1, STOP_SAMPLE + 1);
        check_fifo("t6_pushpop");
        drain();
        pop_one();

        // Randomized byte stream with random pops and occasional framing errors
        for (int n = 0; n < 50; n++) begin
            r = $urandom_range(0, 19);
            if (r < 4)       b = 8'($urandom_range(32'h80, 32'hEF));
            else if (r < 6)  b = 8'($urandom_range(32'hF8, 32'hFF));
            else if (r == 6) b = 8'($urandom_range(32'hF0, 32'hF7));
            else             b = 8'($urandom_range(32'h00, 32'h7F));
            send_byte(b, (r == 7) ? 1'b0 : 1'b1, -1);
            if ($urandom_range(0, 3) == 0) pop_one();
        end
        check_fifo("rand");

        // Reset in the middle of a byte with messages queued
        send3(8'h91, 8'h11, 8'h22);
        @(negedge clk); midi_in = 1'b0;
        repeat (3 * BT) @(negedge clk);
        midi_in = 1'b1;
        repeat (BT / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midreset");
        reset = 1'b0; model_reset();
        repeat (2 * BT) @(negedge clk);
        check_fifo("post_reset");

        check("valid_q_drained", 32'(exp_valid_q.size()), 32'd0);
        check("raw_q_drained", 32'(exp_raw_q.size()), 32'd0);
        check("ferr_total", 32'(ferr_seen), 32'(exp_ferr));
        check("raw_no_overrun", 32'(r_ovr), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
